fetch_ctrl: RTL and testbench



---
 rtl/instr_pack.sv | 16 +
 rtl/fetch_ctrl_jump_lut.sv | 29 ++
 rtl/fetch_ctrl.sv | 116 +++++++++++
 tb/tb_fetch_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_pack.sv
// Shared constants and types for the 9-bit CPU fetch path.
// The CPU top, instr_memory and fetch_ctrl all size themselves from here.
package instr_pack;

    localparam int PC_W      = 10;
    localparam int LUT_DEPTH = 16;
    localparam int LUT_IDX_W = $clog2(LUT_DEPTH);
    localparam int CNT_W     = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl_jump_lut.sv
// Jump-target table: synchronous write, combinational read, async clear.
// A same-cycle write and read of one entry returns the old contents.
module jump_lut #(
    parameter  int DEPTH  = 16,
    parameter  int DATA_W = 10,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [IDX_W-1:0]  i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DEPTH-1:0][DATA_W-1:0] r_mem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem <= '0;
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_ctrl.sv
// Program sequencer: owns the PC, runs on start until halt or PC wrap,
// branches through the jump LUT and counts RUN cycles (saturating).
module fetch_ctrl #(
    parameter  int PC_W      = instr_pack::PC_W,
    parameter  int LUT_DEPTH = instr_pack::LUT_DEPTH,
    parameter  int CNT_W     = instr_pack::CNT_W,
    localparam int LUT_IDX_W = $clog2(LUT_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stall,
    input  logic                 halt,
    input  logic                 branch_en,
    input  logic [LUT_IDX_W-1:0] branch_idx,
    input  logic                 lut_we,
    input  logic [LUT_IDX_W-1:0] lut_waddr,
    input  logic [PC_W-1:0]      lut_wdata,
    output logic [PC_W-1:0]      pc,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun,
    output logic [CNT_W-1:0]     cycles
);

    import instr_pack::*;

    fetch_state_t         r_state;
    logic [PC_W-1:0]      r_pc;
    logic [CNT_W-1:0]     r_cycles;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_ov;

    logic [PC_W-1:0]      w_target;
    logic                 w_pc_max;
    logic                 w_cnt_max;
    logic [CNT_W-1:0]     w_cycles_inc;

    jump_lut #(
        .DEPTH  (LUT_DEPTH),
        .DATA_W (PC_W)
    ) u_lut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (lut_we),
        .i_waddr (lut_waddr),
        .i_wdata (lut_wdata),
        .i_raddr (branch_idx),
        .o_rdata (w_target)
    );

    assign w_pc_max     = &r_pc;
    assign w_cnt_max    = &r_cycles;
    assign w_cycles_inc = w_cnt_max ? r_cycles : r_cycles + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_pc     <= '0;
            r_cycles <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_ov     <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state  <= RUN;
                        r_pc     <= '0;
                        r_cycles <= '0;
                        r_busy   <= 1'b1;
                        r_done   <= 1'b0;
                        r_ov     <= 1'b0;
                    end
                end
                RUN: begin
                    // Decoder flags are only meaningful when the datapath is not holding.
                    if (stall) begin
                        r_cycles <= w_cycles_inc;
                    end else if (halt) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_ov    <= 1'b0;
                    end else if (branch_en) begin
                        r_pc     <= w_target;
                        r_cycles <= w_cycles_inc;
                    end else if (w_pc_max) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_ov    <= 1'b1;
                    end else begin
                        r_pc     <= r_pc + PC_W'(1);
                        r_cycles <= w_cycles_inc;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_pc    <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_ov    <= 1'b0;
                end
            endcase
        end
    end

    assign pc      = r_pc;
    assign busy    = r_busy;
    assign done    = r_done;
    assign overrun = r_ov;
    assign cycles  = r_cycles;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: stimulus pushes model predictions,
// an independent monitor pops and compares them against the DUT outputs.
module tb_fetch_ctrl;

    localparam int PW      = 10;
    localparam int DEPTH   = 16;
    localparam int IW      = 4;
    localparam int CW      = 6;
    localparam int PC_MAX  = (1 << PW) - 1;
    localparam int CYC_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stall = 1'b0;
    logic          halt = 1'b0;
    logic          branch_en = 1'b0;
    logic [IW-1:0] branch_idx = '0;
    logic          lut_we = 1'b0;
    logic [IW-1:0] lut_waddr = '0;
    logic [PW-1:0] lut_wdata = '0;
    logic [PW-1:0] pc;
    logic          busy;
    logic          done;
    logic          overrun;
    logic [CW-1:0] cycles;

    fetch_ctrl #(.PC_W(PW), .LUT_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stall      (stall),
        .halt       (halt),
        .branch_en  (branch_en),
        .branch_idx (branch_idx),
        .lut_we     (lut_we),
        .lut_waddr  (lut_waddr),
        .lut_wdata  (lut_wdata),
        .pc         (pc),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun),
        .cycles     (cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pc;
        int busy;
        int done;
        int ov;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: a program is either not started, running or finished.
    typedef enum {M_IDLE, M_RUN, M_DONE} mst_t;
    mst_t m_st;
    int   m_pc;
    int   m_cyc;
    int   m_ov;
    int   m_lut[DEPTH];

    function automatic void model_reset();
        m_st = M_IDLE; m_pc = 0; m_cyc = 0; m_ov = 0;
        for (int i = 0; i < DEPTH; i++) m_lut[i] = 0;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.pc   = m_pc;
        e.busy = (m_st == M_RUN) ? 1 : 0;
        e.done = (m_st == M_DONE) ? 1 : 0;
        e.ov   = m_ov;
        e.cyc  = m_cyc;
        return e;
    endfunction

    function automatic void model_step(int st, int sl, int hl, int be, int bi, int we, int wa, int wd);
        int tgt;
        tgt = m_lut[bi];
        if (we != 0) m_lut[wa] = wd;
        if (m_st == M_RUN) begin
            if (sl == 0 && hl != 0) begin
                m_st = M_DONE; m_ov = 0;
            end else if (sl == 0 && be == 0 && m_pc == PC_MAX) begin
                m_st = M_DONE; m_ov = 1;
            end else begin
                m_cyc = (m_cyc + 1 > CYC_MAX) ? CYC_MAX : m_cyc + 1;
                if (sl == 0) m_pc = (be != 0) ? tgt : m_pc + 1;
            end
        end else if (st != 0) begin
            m_st = M_RUN; m_pc = 0; m_cyc = 0; m_ov = 0;
        end
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk or negedge rst_n);
            #2;
            while (q.size() > 0) begin
                e = q.pop_front();
                chk("pc", int'(pc), e.pc);
                chk("busy", int'(busy), e.busy);
                chk("done", int'(done), e.done);
                chk("overrun", int'(overrun), e.ov);
                chk("cycles", int'(cycles), e.cyc);
            end
        end
    end

    task automatic cyc(input int st = 0, input int sl = 0, input int hl = 0, input int be = 0,
                       input int bi = 0, input int we = 0, input int wa = 0, input int wd = 0);
        @(negedge clk);
        start      = (st != 0);
        stall      = (sl != 0);
        halt       = (hl != 0);
        branch_en  = (be != 0);
        branch_idx = IW'(bi);
        lut_we     = (we != 0);
        lut_waddr  = IW'(wa);
        lut_wdata  = PW'(wd);
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step(st, sl, hl, be, bi, we, wa, wd);
        q.push_back(model_out());
    endtask

    // Reset dropped between clock edges; outputs must clear before the next edge.
    task automatic async_reset();
        @(negedge clk);
        #2;
        model_reset();
        q.push_back(model_out());
        rst_n = 1'b0;
        cyc();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int r, wd;
        model_reset();
        cyc(); cyc();
        @(negedge clk);
        rst_n = 1'b1;

        // Straight-line run
        cyc(.st(1));
        repeat (5) cyc();

        // Branch through lut[3]
        cyc(.hl(1));
        cyc(.we(1), .wa(3), .wd('h040));
        cyc(.st(1));
        cyc(); cyc();
        cyc(.be(1), .bi(3));
        cyc();

        // Stall at pc 6, then halt+branch at pc 9
        cyc(.hl(1));
        cyc(.st(1));
        repeat (6) cyc();
        repeat (3) cyc(.sl(1));
        cyc(); cyc(); cyc();
        cyc(.hl(1), .be(1), .bi(3));
        cyc(); cyc();
        cyc(.st(1));

        // Same-cycle write and branch sees the old entry
        cyc(.be(1), .bi(5), .we(1), .wa(5), .wd('h200));
        cyc(.be(1), .bi(5));
        cyc();

        // Branch to the last address, then wrap to overrun
        cyc(.we(1), .wa(7), .wd(PC_MAX));
        cyc(.be(1), .bi(7));
        cyc();
        cyc(); cyc();
        cyc(.st(1));

        // Counter saturation and start ignored while running
        repeat (70) cyc(.sl(1));
        cyc(.st(1));
        cyc(.hl(1));

        // Async reset mid-run at pc 0x12 clears the LUT too
        cyc(.st(1));
        repeat (18) cyc();
        async_reset();
        cyc(.st(1));
        cyc(.be(1), .bi(3));
        cyc(.be(1), .bi(7));
        cyc();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 3));
            wd = (r == 0) ? PC_MAX : (r == 1) ? PC_MAX - int'($urandom_range(1, 3))
                                              : int'($urandom_range(0, PC_MAX));
            cyc(.st(($urandom % 20) == 0), .sl(($urandom % 5) == 0), .hl(($urandom % 40) == 0),
                .be(($urandom % 6) == 0), .bi(int'($urandom_range(0, DEPTH - 1))),
                .we(($urandom % 4) == 0), .wa(int'($urandom_range(0, DEPTH - 1))), .wd(wd));
        end

        cyc();
        @(posedge clk);
        #5;
        chk("drain", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
